cla_carry_pipe: RTL and testbench

Downstream consumer of the bitwise generate/propagate stage of the carry-lookahead adder. Takes per-bit p (a^b) and g (a&b) vectors plus carry-in, and computes group P/G, all carries, the sum and carry-out. Two-stage registered pipeline with valid/ready handshakes on both sides. Scales N from 4 to 16 by parameter only.

---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla_group_pg.sv | 25 ++
 rtl/cla_carry_pipe.sv | 147 ++++++++++++++
 tb/tb_cla_carry_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared sizing constants and the per-group propagate/generate reduction
// used by the carry-lookahead pipeline.
package cla_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned GROUP = 4;
  localparam int unsigned NGRP  = N / GROUP;

  // Returns {GP, GG} for one GROUP-bit slice; GG folds from the bottom bit up.
  function automatic logic [1:0] grp_pg(input logic [GROUP-1:0] p_slice,
                                        input logic [GROUP-1:0] g_slice);
    logic gg;
    gg = 1'b0;
    for (int i = 0; i < int'(GROUP); i++) begin
      gg = g_slice[i] | (p_slice[i] & gg);
    end
    return {&p_slice, gg};
  endfunction

endpackage

// File: rtl/cla_group_pg.sv
// Combinational group propagate/generate for one lookahead group.
module cla_group_pg #(
  parameter int unsigned GROUP = cla_pkg::GROUP
) (
  input  logic [GROUP-1:0] p_i,
  input  logic [GROUP-1:0] g_i,
  output logic             gp_o,
  output logic             gg_o
);
  import cla_pkg::grp_pg;

  // The package helper is fixed to the default group width; other widths fold locally.
  if (GROUP == cla_pkg::GROUP) begin : g_pkg
    assign {gp_o, gg_o} = grp_pg(p_i, g_i);
  end else begin : g_loop
    always_comb begin
      gg_o = 1'b0;
      for (int i = 0; i < int'(GROUP); i++) begin
        gg_o = g_i[i] | (p_i[i] & gg_o);
      end
      gp_o = &p_i;
    end
  end

endmodule

// File: rtl/cla_carry_pipe.sv
// Two-stage carry-lookahead back end: S1 captures p/g/cin and group P/G,
// S2 resolves all carries and registers sum, cout and the group terms.
module cla_carry_pipe #(
  parameter  int unsigned N     = cla_pkg::N,
  parameter  int unsigned GROUP = cla_pkg::GROUP,
  localparam int unsigned NGRP  = N / GROUP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    p,
  input  logic [N-1:0]    g,
  input  logic            cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    sum,
  output logic            cout,
  output logic [NGRP-1:0] group_p,
  output logic [NGRP-1:0] group_g
);

  logic [NGRP-1:0] gp_c, gg_c;

  logic            s1_valid_q, s1_valid_d;
  logic [N-1:0]    s1_p_q, s1_p_d;
  logic [N-1:0]    s1_g_q, s1_g_d;
  logic            s1_cin_q, s1_cin_d;
  logic [NGRP-1:0] s1_gp_q, s1_gp_d;
  logic [NGRP-1:0] s1_gg_q, s1_gg_d;

  logic            s2_valid_q, s2_valid_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [NGRP-1:0] grp_p_q, grp_p_d;
  logic [NGRP-1:0] grp_g_q, grp_g_d;

  logic            s2_adv, s1_adv;
  logic [NGRP:0]   grp_c;
  logic [N-1:0]    bit_c;

  for (genvar k = 0; k < int'(NGRP); k++) begin : g_grp
    cla_group_pg #(.GROUP(GROUP)) u_pg (
      .p_i  (p[k*GROUP +: GROUP]),
      .g_i  (g[k*GROUP +: GROUP]),
      .gp_o (gp_c[k]),
      .gg_o (gg_c[k])
    );
  end

  // A stage may advance when it is empty or the stage after it advances.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready = s1_adv;

  // Group carries by lookahead, then ripple inside each group from its group carry.
  always_comb begin
    grp_c    = '0;
    bit_c    = '0;
    grp_c[0] = s1_cin_q;
    for (int k = 0; k < int'(NGRP); k++) begin
      grp_c[k+1] = s1_gg_q[k] | (s1_gp_q[k] & grp_c[k]);
    end
    for (int k = 0; k < int'(NGRP); k++) begin
      for (int j = 0; j < int'(GROUP); j++) begin
        if (j == 0) begin
          bit_c[k*GROUP] = grp_c[k];
        end else begin
          bit_c[k*GROUP+j] = s1_g_q[k*GROUP+j-1] | (s1_p_q[k*GROUP+j-1] & bit_c[k*GROUP+j-1]);
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_cin_d   = s1_cin_q;
    s1_gp_d    = s1_gp_q;
    s1_gg_d    = s1_gg_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    grp_p_d    = grp_p_q;
    grp_g_d    = grp_g_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_p_d   = p;
        s1_g_d   = g;
        s1_cin_d = cin;
        s1_gp_d  = gp_c;
        s1_gg_d  = gg_c;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d   = s1_p_q ^ bit_c;
        cout_d  = grp_c[NGRP];
        grp_p_d = s1_gp_q;
        grp_g_d = s1_gg_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_gp_q    <= '0;
      s1_gg_q    <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      grp_p_q    <= '0;
      grp_g_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_cin_q   <= s1_cin_d;
      s1_gp_q    <= s1_gp_d;
      s1_gg_q    <= s1_gg_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      grp_p_q    <= grp_p_d;
      grp_g_q    <= grp_g_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign group_p   = grp_p_q;
  assign group_g   = grp_g_q;

endmodule

// File: tb/tb_cla_carry_pipe.sv
// Scoreboard bench for cla_carry_pipe: expected results come from plain
// integer addition of the operands that produced each p/g pair.
module tb_cla_carry_pipe;

  localparam int unsigned N    = 16;
  localparam int unsigned NGRP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    p;
  logic [N-1:0]    g;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    sum;
  logic            cout;
  logic [NGRP-1:0] group_p;
  logic [NGRP-1:0] group_g;

  cla_carry_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .g         (g),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .group_p   (group_p),
    .group_g   (group_g)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    sum;
    logic            cout;
    logic [NGRP-1:0] gp;
    logic [NGRP-1:0] gg;
    int              cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  bit              check_lat = 1'b0;
  bit              held      = 1'b0;
  logic [N-1:0]    cur_a, cur_b;
  logic            cur_cin;
  logic [N-1:0]    h_sum;
  logic            h_cout;
  logic [NGRP-1:0] h_gp, h_gg;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full-width addition; group G is the carry out of a 4-bit slice add.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    exp_t        e;
    logic [N:0]  s;
    logic [4:0]  t;
    logic [N-1:0] x;
    s = {1'b0, a} + {1'b0, b} + 17'(c);
    x = a ^ b;
    e.sum  = s[N-1:0];
    e.cout = s[N];
    for (int k = 0; k < 4; k++) begin
      t        = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]};
      e.gg[k]  = t[4];
      e.gp[k]  = (x[4*k +: 4] == 4'hF);
    end
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: stability while stalled, output scoreboard pop, input handshake push.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum",   32'(sum),       32'(h_sum));
        check("hold_cout",  32'(cout),      32'(h_cout));
        check("hold_gp",    32'(group_p),   32'(h_gp));
        check("hold_gg",    32'(group_g),   32'(h_gg));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%0h with no pending transaction", sum);
        end else begin
          e = exp_q.pop_front();
          check("sum",     32'(sum),     32'(e.sum));
          check("cout",    32'(cout),    32'(e.cout));
          check("group_p", 32'(group_p), 32'(e.gp));
          check("group_g", 32'(group_g), 32'(e.gg));
          if (check_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      held   = out_valid && !out_ready;
      h_sum  = sum;
      h_cout = cout;
      h_gp   = group_p;
      h_gg   = group_g;
      if (in_valid && in_ready) begin
        e     = model(cur_a, cur_b, cur_cin);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    cur_a    = a;
    cur_b    = b;
    cur_cin  = c;
    p        = a ^ b;
    g        = a & b;
    cin      = c;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    drive(a, b, c);
    wait_accept();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : drv
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    p         = '0;
    g         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    cur_a     = '0;
    cur_b     = '0;
    cur_cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_group_p",   32'(group_p),   32'd0);
    check("rst_group_g",   32'(group_g),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;

    // Directed vectors and back-to-back throughput with latency checking.
    check_lat = 1'b1;
    send(16'h0003, 16'h0002, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    drain();
    for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();
    check_lat = 1'b0;

    // Backpressure: two accepted, third stalls until the output drains.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0);
    send(16'h8000, 16'h8000, 1'b1);
    drive(16'h00FF, 16'h0F0F, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    drain();

    // Random traffic with random backpressure.
    acc = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(3) != 0);
      if (!in_valid || acc) begin
        if ($urandom_range(3) != 0) drive(16'($urandom), 16'($urandom), 1'($urandom));
        else in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset while both stages hold data: nothing in flight may emerge.
    out_ready = 1'b0;
    send(16'hAAAA, 16'h5555, 1'b1);
    send(16'h0F0F, 16'hF0F0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_cout",      32'(cout),      32'd0);
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_emit", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();
    @(negedge clk);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
